// File: rtl/aud_dsp_player.sv
// aud_dsp_player: playback engine between the recorder SRAM and the DAC serializer.
// Reads one SRAM sample per DAC sample request at speed factor N = i_speed+1.
// Modes: fast (skip N-1 samples), slow constant-hold, slow linear-interpolate.
// Playback runs forward or in reverse, stops itself at the programmed end address,
// and supports pause/resume. A sticky overrun flag records requests that arrive while busy.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start/pause/stop    command pulses (priority stop > pause > start)
//   i_speed, i_mode       N-1 and playback mode (00 fast, 01 const, 10 linear, 11 fast)
//   i_reverse, i_end_addr direction and last valid sample address
//   i_sample_req          one pulse per DAC sample slot
//   i_sram_data           read data for o_sram_addr
//   o_sram_addr           SRAM read address
//   o_dac_data/valid      output sample and its 1-cycle strobe
//   o_done                1-cycle pulse with the last sample of the stream
//   o_overrun             sticky: request arrived during FETCH/CALC
//   o_state               IDLE=0 WAIT=1 FETCH=2 CALC=3 PAUSE=4
module aud_dsp_player #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned SPD_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic [1:0]        i_mode,
  input  logic              i_reverse,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_sample_req,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_dac_valid,
  output logic              o_done,
  output logic              o_overrun,
  output logic [2:0]        o_state
);

  localparam int unsigned N_W    = SPD_W + 1;
  localparam int unsigned PROD_W = DATA_W + SPD_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned NXT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_CALC  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         addr;
  logic [SPD_W-1:0]          k;
  logic [SPD_W-1:0]          spd_l;
  logic [1:0]                mode_l;
  logic                      rev_l;
  logic                      pause_pend;
  logic signed [DATA_W-1:0]  prev;
  logic signed [DATA_W-1:0]  cur;

  // Step / end-of-stream evaluation for the sample currently in CALC
  logic              fast_c;
  logic              wrap_c;
  logic [N_W-1:0]    n_c;
  logic [N_W-1:0]    step_c;
  logic [NXT_W-1:0]  next_c;
  logic              end_c;

  assign fast_c = (mode_l != 2'b01) && (mode_l != 2'b10);
  assign wrap_c = (k == spd_l);
  assign n_c    = N_W'(spd_l) + N_W'(1);
  assign step_c = fast_c ? n_c : (wrap_c ? N_W'(1) : N_W'(0));
  assign next_c = rev_l ? ({1'b0, addr} - NXT_W'(step_c))
                        : ({1'b0, addr} + NXT_W'(step_c));
  // Reverse underflow shows up as the extra MSB; forward overshoot as a compare
  assign end_c  = rev_l ? next_c[ADDR_W] : (next_c > {1'b0, i_end_addr});

  // Linear interpolation: (prev*(N-1-k) + cur*(k+1)) / N, truncating toward zero
  logic [SPD_W-1:0]         w0_c;
  logic [N_W-1:0]           w1_c;
  logic signed [PROD_W-1:0] prev_x, cur_x, w0_x, w1_x, p0_c, p1_c;
  logic signed [SUM_W-1:0]  sum_c, div_c;
  logic [DATA_W-1:0]        lin_c;
  logic [DATA_W-1:0]        out_c;

  assign w0_c   = spd_l - k;
  assign w1_c   = N_W'(k) + N_W'(1);
  assign prev_x = {{(PROD_W-DATA_W){prev[DATA_W-1]}}, prev};
  assign cur_x  = {{(PROD_W-DATA_W){cur[DATA_W-1]}}, cur};
  assign w0_x   = PROD_W'(w0_c);
  assign w1_x   = PROD_W'(w1_c);
  assign p0_c   = prev_x * w0_x;
  assign p1_c   = cur_x * w1_x;
  assign sum_c  = {p0_c[PROD_W-1], p0_c} + {p1_c[PROD_W-1], p1_c};
  assign div_c  = SUM_W'(n_c);
  assign lin_c  = DATA_W'(sum_c / div_c);
  assign out_c  = (mode_l == 2'b10) ? lin_c : cur;

  assign o_sram_addr = addr;
  assign o_state     = state;

  // Playback control, datapath registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      k           <= '0;
      spd_l       <= '0;
      mode_l      <= '0;
      rev_l       <= 1'b0;
      pause_pend  <= 1'b0;
      prev        <= '0;
      cur         <= '0;
      o_dac_data  <= '0;
      o_dac_valid <= 1'b0;
      o_done      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_dac_valid <= 1'b0;
      o_done      <= 1'b0;
      if (i_stop) begin
        state      <= S_IDLE;
        addr       <= '0;
        o_dac_data <= '0;
        pause_pend <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (i_start && !i_pause) begin
              addr       <= i_reverse ? i_end_addr : '0;
              k          <= '0;
              prev       <= '0;
              cur        <= '0;
              o_overrun  <= 1'b0;
              pause_pend <= 1'b0;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (i_pause) begin
              state <= S_PAUSE;
            end else if (i_sample_req) begin
              // Playback parameters only change at a group boundary
              if (k == '0) begin
                mode_l <= i_mode;
                spd_l  <= i_speed;
                rev_l  <= i_reverse;
              end
              state <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (i_pause)      pause_pend <= 1'b1;
            if (i_sample_req) o_overrun  <= 1'b1;
            if (k == '0) begin
              cur  <= i_sram_data;
              prev <= cur;
            end
            state <= S_CALC;
          end
          S_CALC: begin
            if (i_sample_req) o_overrun <= 1'b1;
            o_dac_data  <= out_c;
            o_dac_valid <= 1'b1;
            k           <= (fast_c || wrap_c) ? '0 : k + SPD_W'(1);
            pause_pend  <= 1'b0;
            if (end_c) begin
              o_done <= 1'b1;
              addr   <= '0;
              state  <= S_IDLE;
            end else begin
              addr  <= next_c[ADDR_W-1:0];
              state <= (pause_pend || i_pause) ? S_PAUSE : S_WAIT;
            end
          end
          S_PAUSE: begin
            if (i_start && !i_pause) state <= S_WAIT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
